apb_mem_slave_param: RTL

- Parametrised successor of the APB memory peripheral: an APB4 completer backed by a DEPTH x DATA_WIDTH byte-strobed memory.
- Adds:
  - programmable wait states
  - PSLVERR on out-of-range or misaligned addresses
  - clean transfer-abort handling
  - optional privileged-region protection
- Sits behind the APB interconnect as a generic scratch/config memory.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_mem_slave_param_if.sv | 26 ++
 rtl/apb_strb_mem.sv | 33 +++
 rtl/apb_mem_slave_param.sv | 139 +++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, response codes and address helpers for the APB memory completer.
package apb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;

   localparam logic APB_RESP_OKAY = 1'b0;
   localparam logic APB_RESP_ERR  = 1'b1;

   function automatic logic [63:0] word_index(input logic [63:0] paddr, input int unsigned lsb);
      return paddr >> lsb;
   endfunction

   function automatic logic is_misaligned(input logic [63:0] paddr, input int unsigned lsb);
      return (paddr & ((64'd1 << lsb) - 64'd1)) != 64'd0;
   endfunction

endpackage

// File: rtl/apb_mem_slave_param_if.sv
// rtl/apb_mem_slave_param_if.sv - APB4 bus bundle with requester and completer views.
interface apb_mem_slave_param_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [2:0]              PPROT;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_strb_mem.sv
// rtl/apb_strb_mem.sv - DEPTH x DATA_WIDTH storage with per-byte write enables and one-cycle read.
module apb_strb_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                    clk,
   input  logic [DATA_WIDTH/8-1:0] we,
   input  logic [AW-1:0]           waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [AW-1:0]           raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // Non-power-of-two depths leave unused address codes; those read as zero.
   always_comb begin
      rdata_d = '0;
      if (int'(raddr) < DEPTH) rdata_d = mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      for (int i = 0; i < NB; i++) begin
         if (we[i] && (int'(waddr) < DEPTH)) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/apb_mem_slave_param.sv
// rtl/apb_mem_slave_param.sv - APB4 memory completer with wait states, error response and abort.
// Privileged-region write protection is enabled by defining APB_PROT_CHECK_EN.
module apb_mem_slave_param
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0,
   parameter int PRIV_WORDS  = 4
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   apb_mem_slave_param_if.slave bus
);
   localparam int          NB     = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(DATA_WIDTH / 8);
   localparam int          MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   apb_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]         strb_q, strb_d;
   logic [2:0]            prot_q, prot_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [63:0]           idx_lat, idx_bus;
   logic                  addr_err, prot_err, err;
   logic [NB-1:0]         mem_we;
   logic [MEM_AW-1:0]     mem_raddr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign idx_lat  = word_index(64'(addr_q), LSB);
   assign idx_bus  = word_index(64'(bus.PADDR), LSB);
   assign addr_err = is_misaligned(64'(addr_q), LSB) || (idx_lat >= 64'(DEPTH));

`ifdef APB_PROT_CHECK_EN
   assign prot_err = write_q && !prot_q[0] && (idx_lat < 64'(PRIV_WORDS));
`else
   logic unused_prot;
   assign prot_err    = 1'b0;
   assign unused_prot = ^{prot_q, PRIV_WORDS};
`endif

   assign err = addr_err || prot_err;

   // The read port follows the bus address during setup so read data is ready even with no wait states.
   assign mem_raddr = (state_q == IDLE) ? idx_bus[MEM_AW-1:0] : idx_lat[MEM_AW-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prot_d    = prot_q;
      pready_d  = 1'b0;
      pslverr_d = APB_RESP_OKAY;
      prdata_d  = prdata_q;
      mem_we    = '0;
      case (state_q)
         IDLE: begin
            if (bus.PSEL && !bus.PENABLE) begin
               addr_d  = bus.PADDR;
               write_d = bus.PWRITE;
               wdata_d = bus.PWDATA;
               strb_d  = bus.PSTRB;
               prot_d  = bus.PPROT;
               cnt_d   = 4'(WAIT_STATES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               pready_d  = 1'b1;
               pslverr_d = err ? APB_RESP_ERR : APB_RESP_OKAY;
               if (write_q) begin
                  if (!err && !PRESET) mem_we = strb_q;
               end else begin
                  prdata_d = err ? '0 : mem_rdata;
               end
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   always_ff @(posedge PCLK) begin
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
   end

   apb_strb_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (MEM_AW)
   ) u_mem (
      .clk   (PCLK),
      .we    (mem_we),
      .waddr (idx_lat[MEM_AW-1:0]),
      .wdata (wdata_q),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pslverr_q;
   assign bus.PRDATA  = prdata_q;
endmodule
